// File: rtl/mult_req_sched.sv
// Operand FIFO plus issue/wait/hold sequencer driving a fixed-latency shift-add multiplier.
// Optional MULT_SCHED_ZERO_SKIP_EN: pairs with a zero operand bypass the multiplier.
module mult_req_sched #(
  parameter int M          = 4,
  parameter int MUL_LAT    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   in_a,
  input  logic [M-1:0]   in_b,
  output logic [M-1:0]   mul_a,
  output logic [M-1:0]   mul_b,
  output logic           mul_start,
  input  logic [2*M-1:0] mul_s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-1:0] out_p,
  output logic           busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SKIP,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [2*M-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic           full, empty, push, pop;
  logic [M-1:0]   head_a, head_b;
  logic [CW-1:0]  cnt;

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && !empty;
  assign head_a   = mem[rd_ptr][2*M-1:M];
  assign head_b   = mem[rd_ptr][M-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!empty) begin
`ifdef MULT_SCHED_ZERO_SKIP_EN
          if (head_a == '0 || head_b == '0) state_nxt = S_SKIP;
          else                              state_nxt = S_ISSUE;
`else
          state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_HOLD;
      S_SKIP:  state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mul_start = (state == S_ISSUE);
  assign out_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE) || !empty;

  // Counter loaded in ISSUE so the capture edge is MUL_LAT edges after start is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_a <= '0;
      mul_b <= '0;
      cnt   <= '0;
      out_p <= '0;
    end else begin
      if (pop) begin
        mul_a <= head_a;
        mul_b <= head_b;
      end
      if (state == S_ISSUE)
        cnt <= CW'(MUL_LAT - 1);
      else if (state == S_WAIT && cnt != '0)
        cnt <= cnt - CW'(1);
      if (state == S_WAIT && cnt == '0)
        out_p <= mul_s;
      else if (state == S_SKIP)
        out_p <= '0;
    end
  end

endmodule

// File: tb/tb_mult_req_sched.sv
// Self-checking bench for mult_req_sched: scoreboard of products plus directed timing checks.
module tb_mult_req_sched;

  localparam int M       = 4;
  localparam int MUL_LAT = 10;
  localparam int DEPTH   = 4;
`ifdef MULT_SCHED_ZERO_SKIP_EN
  localparam int ZLAT = 2;
  localparam int ZST  = 0;
`else
  localparam int ZLAT = MUL_LAT + 2;
  localparam int ZST  = 1;
`endif

  logic           clk;
  logic           reset_n;
  logic           in_valid, in_ready;
  logic [M-1:0]   in_a, in_b, mul_a, mul_b;
  logic           mul_start;
  logic [2*M-1:0] mul_s;
  logic           out_valid, out_ready;
  logic [2*M-1:0] out_p;
  logic           busy;

  mult_req_sched #(.M(M), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_s(mul_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_pushes = 0;
  logic [2*M-1:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mul_start) n_starts++;

  // Multiplier stand-in: S is correct only in the cycle before the capture edge.
  logic [2*M-1:0] m_prod = '0;
  int             m_k = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      m_prod <= {4'b0, mul_a} * {4'b0, mul_b};
      m_k    <= MUL_LAT;
    end else if (m_k > 0) begin
      m_k <= m_k - 1;
    end
  end
  assign mul_s = (m_k == 1) ? m_prod : ~m_prod;

  always @(posedge clk) begin
    if (reset_n && in_valid && in_ready) begin
      sb_q.push_back({4'b0, in_a} * {4'b0, in_b});
      n_pushes++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) check("sb_order", out_p, sb_q.pop_front());
    end
  end

  // Called at a negedge with FSM idle; returns the cycle stamp of the accept edge.
  task automatic push_one(input logic [M-1:0] a, input logic [M-1:0] b, output int c0);
    check("push_ready", in_ready, 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    c0 = cyc;
  endtask

  task automatic wait_valid(input string tag, input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) check(tag, out_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy && !out_valid) break;
      @(negedge clk);
    end
    check(tag, busy, 0);
  endtask

  int c0, lat, st0, p0;
  logic [2*M-1:0] held;
  logic seen;
  logic [M-1:0] va [6];
  logic [M-1:0] vb [6];

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_ab", {mul_a, mul_b}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single op with free-running consumer
    st0 = n_starts;
    push_one(4'd13, 4'd11, c0);
    wait_valid("lat_13x11", c0, lat);
    check("lat_13x11", lat, MUL_LAT + 2);
    check("p_13x11", out_p, 8'h8F);
    @(negedge clk);
    check("after_valid", out_valid, 0);
    check("after_busy", busy, 0);
    check("p_kept", out_p, 8'h8F);
    check("starts_13x11", n_starts - st0, 1);

    // Held result, then asynchronous reset while in HOLD
    out_ready = 1'b0;
    push_one(4'd15, 4'd15, c0);
    wait_valid("lat_15x15", c0, lat);
    check("lat_15x15", lat, MUL_LAT + 2);
    check("p_15x15", out_p, 8'hE1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_p", out_p, 0);
    check("arst_mul_ab", {mul_a, mul_b}, 0);
    check("arst_mul_start", mul_start, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill the FIFO with the consumer stalled
    va = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11};
    vb = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12};
    p0 = n_pushes;
    for (int i = 0; i < 5; i++) begin
      in_a = va[i]; in_b = vb[i]; in_valid = 1'b1;
      check("fill_ready", in_ready, 1);
      @(negedge clk);
    end
    in_a = va[5]; in_b = vb[5];
    check("full_ready", in_ready, 0);
    check("fill_count5", n_pushes - p0, 5);
    for (int i = 0; i < 50; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("hold_reached", out_valid, 1);
    held = out_p;
    check("hold_first", held, 8'd2);
    st0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_p", out_p, held);
      check("hold_full", in_ready, 0);
    end
    check("hold_no_start", n_starts - st0, 0);
    check("stall_count", n_pushes - p0, 5);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("stall_release", in_ready, 1);
    @(negedge clk);
    check("fill_count6", n_pushes - p0, 6);
    wait_idle("drain_busy");
    check("drain_empty", sb_q.size(), 0);

    // Reset for one cycle during WAIT drops the op
    @(negedge clk);
    push_one(4'd9, 4'd7, c0);
    repeat (5) @(negedge clk);
    check("wait_busy", busy, 1);
    #2 reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("wrst_busy", busy, 0);
    check("wrst_in_ready", in_ready, 1);
    check("wrst_mul_ab", {mul_a, mul_b}, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    check("drop_no_valid", seen, 0);
    st0 = n_starts;
    push_one(4'd6, 4'd5, c0);
    wait_valid("lat_6x5", c0, lat);
    check("lat_6x5", lat, MUL_LAT + 2);
    check("p_6x5", out_p, 8'h1E);
    wait_idle("idle_6x5");
    check("starts_6x5", n_starts - st0, 1);

    // Zero operand
    @(negedge clk);
    st0 = n_starts;
    push_one(4'd0, 4'd9, c0);
    wait_valid("lat_0x9", c0, lat);
    check("lat_0x9", lat, ZLAT);
    check("p_0x9", out_p, 0);
    wait_idle("idle_0x9");
    check("starts_0x9", n_starts - st0, ZST);
    check("final_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
